// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the 8x8 register file: buffers writes, drains one per cycle, forwards pending data to reads.
// Optional in-place merge of writes to an already-queued register: define WBQ_MERGE_EN.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [AW-1:0]            req_addr,
  input  logic [DW-1:0]            req_data,
  input  logic                     drain_en,
  input  logic                     flush,
  output logic                     we3,
  output logic [AW-1:0]            wa3,
  output logic [DW-1:0]            wd3,
  input  logic [AW-1:0]            ra1,
  input  logic [AW-1:0]            ra2,
  input  logic [DW-1:0]            rf_rd1,
  input  logic [DW-1:0]            rf_rd2,
  output logic [DW-1:0]            rd1,
  output logic [DW-1:0]            rd2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_accept;
  logic w_push;
  logic w_merge;
  logic w_mhit;
  logic [PW-1:0] w_midx;

  // Slot holding the i-th oldest entry, counted from the head.
  function automatic logic [PW-1:0] f_slot(input logic [PW-1:0] head, input int i);
    return PW'(head + PW'(i));
  endfunction

  // Walk oldest to youngest so the youngest matching entry wins.
  function automatic logic [DW-1:0] f_fwd(input logic [AW-1:0] ra, input logic [DW-1:0] rf);
    logic [DW-1:0] d;
    logic [PW-1:0] s;
    d = rf;
    for (int i = 0; i < DEPTH; i++) begin
      s = f_slot(r_head, i);
      if (r_vld[s] && (r_addr[s] == ra)) d = r_data[s];
    end
    if (ra == '0) d = '0;
    return d;
  endfunction

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = !w_empty && drain_en && !flush;

`ifdef WBQ_MERGE_EN
  // The head leaving this cycle cannot absorb a merge; a younger match still can.
  always_comb begin
    w_mhit = 1'b0;
    w_midx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[f_slot(r_head, i)] && (r_addr[f_slot(r_head, i)] == req_addr) &&
          !(w_pop && (f_slot(r_head, i) == r_head))) begin
        w_mhit = 1'b1;
        w_midx = f_slot(r_head, i);
      end
    end
  end
  assign req_ready = !w_full || (req_valid && w_mhit);
`else
  assign w_mhit    = 1'b0;
  assign w_midx    = '0;
  assign req_ready = !w_full;
`endif

  assign w_accept = req_valid && req_ready && !flush;
  assign w_merge  = w_accept && w_mhit;
  assign w_push   = w_accept && (req_addr != '0) && !w_mhit;

  assign we3   = w_pop;
  assign wa3   = w_empty ? '0 : r_addr[r_head];
  assign wd3   = w_empty ? '0 : r_data[r_head];
  assign rd1   = f_fwd(ra1, rf_rd1);
  assign rd2   = f_fwd(ra2, rf_rd2);
  assign count = r_count;
  assign empty = w_empty;
  assign full  = w_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= PW'(r_head + PW'(1));
      end
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= PW'(r_tail + PW'(1));
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy is tracked by r_vld alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= req_addr;
      r_data[r_tail] <= req_data;
    end
    if (w_merge) r_data[w_midx] <= req_data;
  end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-side front end for the 8x8-bit register file (3-bit addresses, $0 hardwired to zero).
- Buffers register write requests from the datapath in a small FIFO and drains them, one per cycle, into the register file port (we3/wa3/wd3).
- Forwards not-yet-committed data to the two read ports, so consumers see the newest value of every register.
- Sits between the execute/writeback stage and the register file.

Parameters:
DEPTH, 4, number of queue entries (power of two, 2..16)
AW, 3, register address width
DW, 8, register data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active low (0 = reset)
req_valid  in  1  write request valid
req_ready  out  1  queue can accept a request this cycle
req_addr  in  AW  destination register
req_data  in  DW  data to write
drain_en  in  1  1 = allow commit to register file; 0 = hold queue
flush  in  1  synchronous discard of all pending entries
we3  out  1  to register file write enable
wa3  out  AW  to register file write address
wd3  out  DW  to register file write data
ra1  in  AW  read address 1 (also driven to register file)
ra2  in  AW  read address 2 (also driven to register file)
rf_rd1  in  DW  raw register file read data 1
rf_rd2  in  DW  raw register file read data 2
rd1  out  DW  forwarded read data 1
rd2  out  DW  forwarded read data 2
count  out  log2(DEPTH)+1  occupied entries
empty  out  1  count == 0
full  out  1  count == DEPTH

Behaviour:
- Reset (rst=0, async): head = tail = count = 0, entry valid bits cleared. Outputs: we3=0, wa3=0, wd3=0, empty=1, full=0, req_ready=1.
- Handshake:
  - req_ready = !full (combinational).
  - Push at rising edge when req_valid && req_ready.
  - req_addr == 0: accepted (handshake completes) but not queued, because $0 is never written.
- Commit path:
  - we3 = !empty && drain_en, combinational from the head entry; wa3/wd3 = head addr/data (0 when empty).
  - Pop at the same edge at which the register file samples.
  - Latency: a request accepted at edge N is committed at edge N+1 at the earliest.
- Simultaneous push and pop: count is unchanged. When full, push is blocked even if a pop occurs (req_ready does not depend on pop).
- Pointers wrap modulo DEPTH.
- Flush:
  - At the edge, clears all entries and count, and suppresses any push that cycle.
  - we3 is forced to 0 in the flush cycle.
- Forwarding for rd1 (rd2 identical with ra2/rf_rd2):
  - ra1 == 0: rd1 = 0.
  - Otherwise, the youngest valid entry with addr == ra1 supplies its data.
  - With no match, rd1 = rf_rd1.
  - Purely combinational. Same-cycle incoming requests are not forwarded.
  - The head entry being committed this cycle still forwards.
- drain_en = 0: the queue holds and fills. When full, req_ready = 0 and the producer stalls.
- Reset mid-operation: all pending writes are lost. The register file is reset by the same rst.

Optional Feature:
WBQ_MERGE_EN
- Defined: a push whose req_addr matches a valid entry overwrites that entry's data in place (youngest match) instead of allocating a new slot.
- A merge is allowed even when full, so req_ready = !full || (req_valid && match).
- Exception: if the only match is the head being popped that cycle, the request allocates normally (blocked if full).
- Undefined: no merging; every non-zero request allocates a slot.

Test Plan:
- Reset, then push (addr 3, 0x5A) with drain_en=1 -> we3=1, wa3=3, wd3=0x5A in the next cycle; count returns to 0 after one edge.
- drain_en=0, push 4 requests (1:0x11, 2:0x22, 3:0x33, 4:0x44) -> full=1, req_ready=0; the fifth request stalls. Set drain_en=1 -> commits in order 1,2,3,4 on consecutive cycles.
- drain_en=0, push (5:0xAA) then (5:0xBB), ra1=5, rf_rd1=0x00 -> rd1=0xBB. Set ra2=0 -> rd2=0.
- Push to addr 0 with data 0xFF -> handshake completes, count stays 0, we3 never asserts.
- Queue holding 3 entries, assert flush and req_valid together -> count=0, empty=1, no we3 pulse, the new request is discarded.
- WBQ_MERGE_EN defined: full queue, push (2:0x99) with entry 2 not at head -> accepted; count stays 4; entry 2 is later committed with 0x99.
